// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared constants and state type for the ring-oscillator frequency path
package ro_pkg;

    localparam int RO_CNT_W_DEF       = 32;
    localparam int RO_SYNC_STAGES_DEF = 2;

    // Measurement state, also decoded by the UART formatter.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } ro_state_t;

endpackage

// File: rtl/ro_sync_edge.sv
// rtl/ro_sync_edge.sv - ro_in synchronizer chain and rising-edge detector
module ro_sync_edge
    import ro_pkg::*;
#(
    parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous input through the synchronizer, then keep one older sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One pulse per oscillator period: synchronized value high, previous sample low.
    always_comb begin
        edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

endmodule

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - gated edge counter with latched valid/ready result (COUNT_SAT_EN selects saturation)
module ro_edge_counter
    import ro_pkg::*;
#(
    parameter int CNT_W       = RO_CNT_W_DEF,
    parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ro_in,
    input  logic             window_done,
    output logic [CNT_W-1:0] count_data,
    output logic             count_ovf,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             drop
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ro_state_t        state_q;
    ro_state_t        state_d;
    logic             count_active;
    logic             edge_pulse;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_q;
    logic             ovf_next;
    logic             latch;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .ro_in      (ro_in),
        .edge_pulse (edge_pulse)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows the enable directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = COUNT;
            COUNT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State decode: counting and window latching happen only in COUNT.
    always_comb begin
        count_active = (state_q == COUNT);
    end

    // Count including this cycle's edge; this is also the value latched on window_done.
`ifdef COUNT_SAT_EN
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (edge_pulse) begin
            if (cnt_q == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_ONE;
            end
        end
    end
`else
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (edge_pulse) begin
            cnt_next = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX) begin
                ovf_next = 1'b1;
            end
        end
    end
`endif

    // The edge coincident with window_done closes into the current result.
    always_comb begin
        latch = count_active && window_done;
    end

    // Counter and sticky overflow; cleared when idle, on disable and at each window boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (!en || !count_active || window_done) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

    // Result register: a new latch always wins; drop flags an unaccepted result being replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_data  <= '0;
            count_ovf   <= 1'b0;
            count_valid <= 1'b0;
            drop        <= 1'b0;
        end else begin
            drop <= latch && count_valid && !count_ready;
            if (latch) begin
                count_data  <= cnt_next;
                count_ovf   <= ovf_next;
                count_valid <= 1'b1;
            end else if (count_valid && count_ready) begin
                count_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ro_edge_counter.md
# ro_edge_counter

Gated edge counter that consumes the one-cycle window pulse and turns it into a frequency measurement. It counts rising edges of the asynchronous ring-oscillator signal while measurement is enabled. On each window pulse it latches the count into an output register offered with a valid/ready handshake. It sits between the window timer and the UART transmit formatter.

## Interface
- CNT_W, 32: width of the edge counter and of count_data.
- SYNC_STAGES, 2: flops in the ro_in synchronizer; minimum 2.

- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- en  in  1  measurement enable; the same signal that gates the window timer.
- ro_in  in  1  asynchronous ring-oscillator output, pre-divided so its toggle rate is below clk/2.
- window_done  in  1  one-cycle pulse marking the end of a measurement window.
- count_data  out  CNT_W  latched edge count of the last completed window.
- count_ovf  out  1  qualifies count_data: the counter overflowed in that window.
- count_valid  out  1  count_data/count_ovf hold a result not yet accepted.
- count_ready  in  1  consumer accepts the result when count_valid && count_ready.
- drop  out  1  one-cycle pulse when an unaccepted result is overwritten.

## Operation
- ro_in passes through SYNC_STAGES flops, then a previous-value flop.
- A rising edge is sync_out=1 && prev=0, producing one edge per oscillator period.
- States:
  - IDLE: en=0; counter held at 0; window_done ignored.
  - COUNT: en=1; counter += 1 on each detected edge.
- IDLE→COUNT when en=1; COUNT→IDLE when en=0.
- Deasserting en discards the partial window: counter cleared the next cycle.
- window_done in COUNT:
  - Latch result = counter + (edge this cycle ? 1 : 0).
  - Counter restarts at 0 the next cycle. The edge coincident with window_done belongs to the closing window.
- Output register:
  - Loaded on the latch.
  - count_valid set; it clears only on the handshake.
  - count_data/count_ovf stable while count_valid=1 && count_ready=0.
- Latch while count_valid=1 && count_ready=0: new result overwrites the old one, count_valid stays 1, drop pulses.
- Latch in the same cycle as a handshake: old result is accepted, new one loads, count_valid stays 1, no drop.
- Pending output survives en deassertion until accepted.
- Overflow (counter at all-ones and an edge arrives) behaves per Configuration. The ovf flag is sticky per window and is cleared with the counter.

## Timing
- Reset values:
  - count_data=0, count_ovf=0, count_valid=0, drop=0.
  - Counter 0; synchronizer and prev flops 0; state IDLE.
- ro_in rising edge to counter increment: SYNC_STAGES+1 cycles.
- window_done to count_valid=1 and new count_data: 1 cycle.
- drop asserts in the same cycle the overwritten data changes.
- count_ready has no combinational path to any output.
- rst mid-window or mid-handshake: everything returns to reset values the next cycle. A pending result is lost, with no drop pulse.
- First edge after reset: if ro_in is high at reset release, one edge is detected SYNC_STAGES+1 cycles later. It is counted only if en=1.

## Configuration
- COUNT_SAT_EN defined: counter saturates at 2^CNT_W-1; further edges are ignored; count_ovf=1 for that window.
- COUNT_SAT_EN undefined: counter wraps modulo 2^CNT_W; count_ovf=1 if any wrap occurred in the window.

## Structure
- Shared package ro_pkg holds:
  - Default CNT_W and SYNC_STAGES constants.
  - The IDLE/COUNT state typedef, shared with the UART formatter.
- One sub-module, ro_sync_edge: synchronizer chain plus rising-edge detector, output edge_pulse.
- The counter, FSM and output register stay in ro_edge_counter.

## Test plan
- Basic count: CNT_W=32, en=1, 37 ro_in edges (period 8 clk), then window_done → next cycle count_valid=1, count_data=37, count_ovf=0.
- Coincident edge: synchronized edge arrives in the same cycle as window_done → counted in the closing window (38). The next window starts at 0.
- Backpressure: count_ready=0 across two windows of 10 and 12 edges → drop pulses once, count_data=12. Raise count_ready → count_valid=0 the next cycle.
- Accept/load collision: count_ready=1 in the same cycle as window_done with a pending result → no drop, count_valid stays 1, new value visible.
- Overflow: CNT_W=8, 300 edges in one window:
  - With COUNT_SAT_EN: count_data=255, count_ovf=1.
  - Without: count_data=44, count_ovf=1.
- Abort/reset: en dropped after 20 edges, re-enabled, 5 edges, window_done → count_data=5. rst asserted while count_valid=1 → all outputs 0 the next cycle.
